// File: rtl/sync_frame_pkg.sv
// Shared constants and state encoding for the serial frame transmitter.
// The sync word precedes each payload when SYNC_FRAME_TX_PREAMBLE_EN is defined.
package sync_frame_pkg;

    localparam int SYNC_W = 12;
    localparam logic [SYNC_W-1:0] SYNC_WORD = 12'b1110_1101_1011;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_frame_tx_piso_shift.sv
// Parallel-load, left-shift register holding the payload word of the current frame.
// msb_next_o is the MSB the register will hold after this edge, so the caller can register it.
module piso_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              msb_next_o
);

    logic [DATA_W-1:0] sh_q;
    logic [DATA_W-1:0] sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = data_i;
        end else if (shift_i) begin
            sh_d = sh_q << 1;
        end
    end

    assign msb_next_o = sh_d[DATA_W-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: optional 12-bit sync word (SYNC_FRAME_TX_PREAMBLE_EN) then payload, MSB-first.
// Outputs are registered from next-state values so ser_out lines up with the state it belongs to.
module sync_frame_tx
    import sync_frame_pkg::*;
#(
    parameter int   DATA_W     = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(max_int(SYNC_W, DATA_W));
    localparam logic [CNT_W-1:0] LAST_PAY = CNT_W'(DATA_W - 1);

`ifdef SYNC_FRAME_TX_PREAMBLE_EN
    localparam logic [CNT_W-1:0] LAST_SYNC   = CNT_W'(SYNC_W - 1);
    localparam state_t           FIRST_STATE = SYNC;
`else
    localparam state_t           FIRST_STATE = PAYLOAD;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             load, shift, msb_next, accept;

    assign in_ready = (state_q == IDLE) || ((state_q == PAYLOAD) && (cnt_q == LAST_PAY));
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != IDLE);

    piso_shift #(
        .DATA_W(DATA_W)
    ) u_piso (
        .clk       (clk),
        .reset     (reset),
        .load_i    (load),
        .shift_i   (shift),
        .data_i    (in_data),
        .msb_next_o(msb_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    state_d = FIRST_STATE;
                    cnt_d   = '0;
                end
            end
`ifdef SYNC_FRAME_TX_PREAMBLE_EN
            SYNC: begin
                if (cnt_q == LAST_SYNC) begin
                    state_d = PAYLOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            PAYLOAD: begin
                if (cnt_q == LAST_PAY) begin
                    cnt_d = '0;
                    if (accept) begin
                        // back-to-back: next frame starts without an idle bit
                        load    = 1'b1;
                        state_d = FIRST_STATE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    shift = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef SYNC_FRAME_TX_PREAMBLE_EN
    logic [3:0] sync_idx;
    always_comb begin
        sync_idx = 4'(LAST_SYNC - cnt_d);
    end
`endif

    always_comb begin
        ser_out_d    = IDLE_LEVEL;
        ser_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        case (state_d)
`ifdef SYNC_FRAME_TX_PREAMBLE_EN
            SYNC: begin
                ser_out_d   = SYNC_WORD[sync_idx];
                ser_valid_d = 1'b1;
            end
`endif
            PAYLOAD: begin
                ser_out_d    = msb_next;
                ser_valid_d  = 1'b1;
                frame_done_d = (cnt_d == LAST_PAY);
            end
            default: begin
                ser_out_d = IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ser_out_q    <= IDLE_LEVEL;
            ser_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ser_out_q    <= ser_out_d;
            ser_valid_q  <= ser_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ser_out    = ser_out_q;
    assign ser_valid  = ser_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed bench for sync_frame_tx: table of single frames, then back-to-back and mid-frame reset.
// Expectations follow SYNC_FRAME_TX_PREAMBLE_EN the same way the design does.
module tb_sync_frame_tx;

    localparam int DATA_W = 8;
    localparam logic IDLE_LVL = 1'b0;
`ifdef SYNC_FRAME_TX_PREAMBLE_EN
    localparam int SYNC_LEN = 12;
`else
    localparam int SYNC_LEN = 0;
`endif
    localparam int FLEN = SYNC_LEN + DATA_W;
    localparam logic [11:0] SYNC_EXP = 12'b1110_1101_1011;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              ser_out;
    logic              ser_valid;
    logic              busy;
    logic              frame_done;

    int total = 0;
    int bad   = 0;

    sync_frame_tx #(
        .DATA_W    (DATA_W),
        .IDLE_LEVEL(IDLE_LVL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .busy      (busy),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loopback model of the downstream 12-bit sync detector.
    logic [11:0] det_sh = 12'd0;
    logic        det;
    int          det_cnt = 0;
    assign det = (det_sh == SYNC_EXP);
    always @(posedge clk) begin
        det_sh <= {det_sh[10:0], ser_out};
        if (det === 1'b1) det_cnt <= det_cnt + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_pay;
        bit         bp;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] pay, input int c);
        if (c <= SYNC_LEN) return SYNC_EXP[12-c];
        return pay[FLEN-c];
    endfunction

    task automatic chk_idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("idle_ser_out", 32'(ser_out), 32'(IDLE_LVL));
            chk("idle_ser_valid", 32'(ser_valid), 0);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_frame_done", 32'(frame_done), 0);
            chk("idle_in_ready", 32'(in_ready), 1);
        end
    endtask

    task automatic run_frame(input vec_t v);
        int d0;
        int bad0;
        bad0 = bad;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v.data;
        chk("accept_in_ready", 32'(in_ready), 1);
        d0 = det_cnt;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~v.data;
        for (int c = 1; c <= FLEN; c++) begin
            @(negedge clk);
            chk("ser_out", 32'(ser_out), 32'(exp_bit(v.exp_pay, c)));
            chk("ser_valid", 32'(ser_valid), 1);
            chk("busy", 32'(busy), 1);
            chk("frame_done", 32'(frame_done), 32'(c == FLEN));
            chk("in_ready", 32'(in_ready), 32'(c == FLEN));
            if (SYNC_LEN > 0 && c == SYNC_LEN + 1) chk("detect_cycle", 32'(det), 1);
            if (v.bp && c >= 5 && c <= 10 && c < FLEN) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b0;
            end
        end
        chk_idle(3);
        chk("detect_count", 32'(det_cnt - d0), 32'(SYNC_LEN > 0 ? 1 : 0));
        $display("frame data=%02h bp=%0d errors=%0d", v.data, v.bp, bad - bad0);
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, exp_pay: 8'b1010_0101, bp: 1'b0};
        vecs[1] = '{data: 8'h3C, exp_pay: 8'b0011_1100, bp: 1'b1};
        vecs[2] = '{data: 8'hFF, exp_pay: 8'b1111_1111, bp: 1'b0};
        vecs[3] = '{data: 8'h00, exp_pay: 8'b0000_0000, bp: 1'b1};
        vecs[4] = '{data: 8'h81, exp_pay: 8'b1000_0001, bp: 1'b1};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        #2;
        chk("rst_ser_out", 32'(ser_out), 32'(IDLE_LVL));
        chk("rst_ser_valid", 32'(ser_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_idle(2);
        $display("reset check errors=%0d", bad);

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // Back-to-back: FF then 00 with in_valid held high.
        begin
            int bad0;
            bad0 = bad;
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'hFF;
            @(posedge clk);
            #1;
            in_data = 8'h00;
            for (int c = 1; c <= 2 * FLEN; c++) begin
                int pos;
                logic [7:0] pay;
                pos = (c <= FLEN) ? c : c - FLEN;
                pay = (c <= FLEN) ? 8'b1111_1111 : 8'b0000_0000;
                @(negedge clk);
                chk("b2b_ser_out", 32'(ser_out), 32'(exp_bit(pay, pos)));
                chk("b2b_ser_valid", 32'(ser_valid), 1);
                chk("b2b_frame_done", 32'(frame_done), 32'(pos == FLEN));
                chk("b2b_in_ready", 32'(in_ready), 32'(pos == FLEN));
                if (c == FLEN) begin
                    @(posedge clk);
                    #1;
                    in_valid = 1'b0;
                end
            end
            chk_idle(3);
            $display("back-to-back FF,00 errors=%0d", bad - bad0);
        end

        // Reset mid-payload: outputs must drop without a clock edge.
        begin
            int bad0;
            bad0 = bad;
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'hA5;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            for (int c = 1; c <= SYNC_LEN + 3; c++) @(negedge clk);
            chk("mid_ser_valid_before", 32'(ser_valid), 1);
            #1;
            reset = 1'b1;
            #1;
            chk("mid_rst_ser_out", 32'(ser_out), 32'(IDLE_LVL));
            chk("mid_rst_ser_valid", 32'(ser_valid), 0);
            chk("mid_rst_in_ready", 32'(in_ready), 1);
            chk("mid_rst_busy", 32'(busy), 0);
            chk("mid_rst_frame_done", 32'(frame_done), 0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("mid_rst_hold_done", 32'(frame_done), 0);
            end
            reset = 1'b0;
            for (int k = 0; k < FLEN; k++) begin
                @(negedge clk);
                chk("after_rst_done", 32'(frame_done), 0);
                chk("after_rst_valid", 32'(ser_valid), 0);
            end
            $display("reset mid-payload errors=%0d", bad - bad0);
        end

        run_frame('{data: 8'h5A, exp_pay: 8'b0101_1010, bp: 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_frame_tx.md
# sync_frame_tx

Serial frame transmitter feeding the 12-bit sync-word detector's serial input. It accepts a parallel payload word over a valid/ready handshake. It then emits the 12-bit sync word 1110_1101_1011 MSB-first, followed by the payload MSB-first, one bit per clock. Between frames the line holds a configurable idle level.

## Interface
- DATA_W, 8: payload width in bits, minimum 1.
- IDLE_LEVEL, 0: value driven on ser_out when no frame bit is being sent.

- clk  input  1  clock; all sampling on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_data  input  DATA_W  payload word.
- in_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial bit stream, registered.
- ser_valid  output  1  ser_out carries a frame bit (sync or payload), registered.
- busy  output  1  a frame is in progress (state not IDLE).
- frame_done  output  1  one-cycle pulse, high while the last payload bit is on ser_out.

## Operation
- FSM states: IDLE, SYNC, PAYLOAD.
- IDLE:
  - ser_out = IDLE_LEVEL; ser_valid = 0.
  - On in_valid && in_ready, latch in_data into the shift register and go to SYNC, with bit counter = 0.
- SYNC:
  - Drives SYNC_WORD[11-cnt] for cnt = 0..11.
  - After cnt 11, go to PAYLOAD with cnt = 0.
- PAYLOAD:
  - Drives shift register MSB, then shifts left each cycle, for DATA_W cycles.
  - On the last bit (cnt = DATA_W-1):
    - If in_valid && in_ready, latch the new word and go to SYNC (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- in_ready = (state == IDLE) || (state == PAYLOAD && cnt == DATA_W-1). It is combinational from state and counter.
- in_data is ignored whenever in_ready = 0. The held word is unaffected by in_data changes mid-frame.
- Counter width is $clog2(max(12, DATA_W)). The counter never wraps past its terminal value within a state.
- Reset values:
  - state IDLE, cnt 0, shift register 0.
  - ser_out = IDLE_LEVEL, ser_valid = 0, frame_done = 0, busy = 0.
  - in_ready reads 1 once reset is asserted (state IDLE).
- Reset mid-frame: the frame is aborted immediately (asynchronous). No frame_done is generated, and the partial word is discarded.

## Timing
- Accept edge is cycle 0; the first sync bit appears on ser_out in cycle 1.
- With the sync word: sync occupies cycles 1–12 and payload occupies cycles 13..12+DATA_W.
- frame_done is high in cycle 12+DATA_W only.
- Frame length is 12+DATA_W cycles. Sustained throughput is one word per 12+DATA_W cycles, with no gap cycles.
- ser_valid is high exactly in frame-bit cycles.
- busy is high from cycle 1 through the last bit of the last queued frame.

## Configuration
- SYNC_FRAME_TX_PREAMBLE_EN defined:
  - The SYNC state is compiled in, as described above.
  - Frame length is 12+DATA_W.
- Not defined:
  - The SYNC state is removed, and IDLE/back-to-back accepts go directly to PAYLOAD.
  - Payload occupies cycles 1..DATA_W, and frame_done is in cycle DATA_W.
  - Frame length is DATA_W.

## Structure
- Shared package sync_frame_pkg holds:
  - SYNC_W = 12.
  - SYNC_WORD = 12'b1110_1101_1011.
  - The state typedef (IDLE, SYNC, PAYLOAD).
- One sub-module, piso_shift:
  - Parallel-load, left-shift DATA_W register with load/shift enables.
  - Its MSB output feeds the ser_out mux.
- The FSM, counter and output registers live in sync_frame_tx.

## Test plan
- Single frame, preamble enabled, DATA_W=8: in_data=8'hA5 accepted at cycle 0 -> expect:
  - ser_out cycles 1–12 = 1,1,1,0,1,1,0,1,1,0,1,1.
  - ser_out cycles 13–20 = 1,0,1,0,0,1,0,1.
  - frame_done only in cycle 20.
  - ser_out = IDLE_LEVEL and ser_valid = 0 from cycle 21.
- Back-to-back: in_valid held high with 8'hFF then 8'h00 -> expect:
  - Second accept in cycle 20.
  - Second sync starts in cycle 21, with no idle bit.
  - in_ready is low in cycles 1–19.
- Backpressure: in_valid pulsed during cycles 5–10 of a frame -> word not accepted; the in-flight payload is unchanged.
- Reset mid-payload (asserted in cycle 15) -> expect, without a clock edge:
  - ser_out = IDLE_LEVEL and ser_valid = 0.
  - No frame_done.
  - in_ready = 1.
- Preamble macro undefined, DATA_W=8: in_data=8'h3C -> expect ser_out cycles 1–8 = 0,0,1,1,1,1,0,0 and frame_done in cycle 8.
- Loopback into the 12-bit sync detector -> expect exactly one detect per frame, on the cycle after the twelfth sync bit is sampled.
